// File: rtl/pp_buffer_reader_if.sv
// Bus between the ping-pong reader, its two RAM banks, the bank writer and the downstream stage.
// Framing signals exist only when PP_READER_FRAMING_EN is defined.
interface pp_buffer_reader_if #(
   parameter int ADDR_W = 8
);
   logic              full_A;
   logic              full_B;
   logic [ADDR_W-1:0] rdaddress;
   logic              rden_A;
   logic              rden_B;
   logic              q_A;
   logic              q_B;
   logic              release_A;
   logic              release_B;
   logic              q;
   logic              valid_next;
   logic              ready_next;
   logic              overrun;
`ifdef PP_READER_FRAMING_EN
   logic              sob_next;
   logic              eob_next;
`endif

   modport master (
      input  full_A, full_B, q_A, q_B, ready_next,
      output rdaddress, rden_A, rden_B, release_A, release_B, q, valid_next, overrun
`ifdef PP_READER_FRAMING_EN
      , output sob_next, eob_next
`endif
   );

   modport slave (
      output full_A, full_B, q_A, q_B, ready_next,
      input  rdaddress, rden_A, rden_B, release_A, release_B, q, valid_next, overrun
`ifdef PP_READER_FRAMING_EN
      , input sob_next, eob_next
`endif
   );
endinterface

// File: rtl/pp_buffer_reader.sv
// Drains ping-pong bit banks strictly A,B,A,... into a valid/ready bit stream; 2-entry output FIFO with
// fall-through of the in-flight RAM read. PP_READER_FRAMING_EN adds sob_next/eob_next per bit.
module pp_buffer_reader #(
   parameter int BLOCK_BITS = 192,
   parameter int ADDR_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   pp_buffer_reader_if.master bus
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_BITS - 1);
`ifdef PP_READER_FRAMING_EN
   localparam int EW = 3;
`else
   localparam int EW = 1;
`endif

   typedef enum logic [1:0] {WAIT_A, READ_A, WAIT_B, READ_B} state_t;

   state_t            state_q, state_d;
   logic              pend_a_q, pend_a_d, pend_b_q, pend_b_d;
   logic              overrun_q, overrun_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              inflight_q, inflight_d;
   logic              bank_b_q, bank_b_d;
   logic              rel_a_q, rel_a_d, rel_b_q, rel_b_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]     mem_q [2];
`ifdef PP_READER_FRAMING_EN
   logic              sob_tag_q, sob_tag_d, eob_tag_q, eob_tag_d;
`endif

   logic              rden_a, rden_b, issue, at_last, room;
   logic              out_vld, pop, push, fifo_pop, rd_bit;
   logic [2:0]        occ;
   logic [EW-1:0]     in_ent, head_ent;

   // The bit returned by last cycle's read is presented directly when the FIFO is empty.
   assign rd_bit   = bank_b_q ? bus.q_B : bus.q_A;
`ifdef PP_READER_FRAMING_EN
   assign in_ent   = {eob_tag_q, sob_tag_q, rd_bit};
`else
   assign in_ent   = rd_bit;
`endif
   assign out_vld  = (cnt_q != 2'd0) | inflight_q;
   assign head_ent = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : in_ent;
   assign pop      = out_vld & bus.ready_next;
   assign push     = inflight_q & ~((cnt_q == 2'd0) & pop);
   assign fifo_pop = pop & (cnt_q != 2'd0);

   assign occ      = {1'b0, cnt_q} + {2'b00, inflight_q};
   assign room     = occ < (3'd2 + {2'b00, pop});
   assign at_last  = (addr_q == LAST_ADDR);
   assign rden_a   = (state_q == READ_A) & room;
   assign rden_b   = (state_q == READ_B) & room;
   assign issue    = rden_a | rden_b;

   assign bus.rdaddress  = addr_q;
   assign bus.rden_A     = rden_a;
   assign bus.rden_B     = rden_b;
   assign bus.release_A  = rel_a_q;
   assign bus.release_B  = rel_b_q;
   assign bus.overrun    = overrun_q;
   assign bus.valid_next = out_vld;
   assign bus.q          = out_vld & head_ent[0];
`ifdef PP_READER_FRAMING_EN
   assign bus.sob_next   = out_vld & head_ent[1];
   assign bus.eob_next   = out_vld & head_ent[2];
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      inflight_d = issue;
      bank_b_d   = bank_b_q;
      rel_a_d    = rden_a & at_last;
      rel_b_d    = rden_b & at_last;
      cnt_d      = cnt_q + {1'b0, push} - {1'b0, fifo_pop};
      wr_ptr_d   = wr_ptr_q ^ push;
      rd_ptr_d   = rd_ptr_q ^ fifo_pop;
`ifdef PP_READER_FRAMING_EN
      sob_tag_d  = sob_tag_q;
      eob_tag_d  = eob_tag_q;
`endif

      // A new full pulse wins over a same-cycle release; only a full on a still-pending bank overruns.
      pend_a_d   = bus.full_A | (pend_a_q & ~rel_a_q);
      pend_b_d   = bus.full_B | (pend_b_q & ~rel_b_q);
      overrun_d  = overrun_q
                 | (bus.full_A & pend_a_q & ~rel_a_q)
                 | (bus.full_B & pend_b_q & ~rel_b_q);

      case (state_q)
         WAIT_A:  if (pend_a_q)          state_d = READ_A;
         READ_A:  if (rden_a && at_last) state_d = WAIT_B;
         WAIT_B:  if (pend_b_q)          state_d = READ_B;
         READ_B:  if (rden_b && at_last) state_d = WAIT_A;
         default:                        state_d = WAIT_A;
      endcase

      if (issue) begin
         addr_d   = at_last ? '0 : addr_q + ADDR_W'(1);
         bank_b_d = rden_b;
`ifdef PP_READER_FRAMING_EN
         sob_tag_d = (addr_q == '0);
         eob_tag_d = at_last;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= WAIT_A;
         pend_a_q   <= 1'b0;
         pend_b_q   <= 1'b0;
         overrun_q  <= 1'b0;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         bank_b_q   <= 1'b0;
         rel_a_q    <= 1'b0;
         rel_b_q    <= 1'b0;
         cnt_q      <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
`ifdef PP_READER_FRAMING_EN
         sob_tag_q  <= 1'b0;
         eob_tag_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pend_a_q   <= pend_a_d;
         pend_b_q   <= pend_b_d;
         overrun_q  <= overrun_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         bank_b_q   <= bank_b_d;
         rel_a_q    <= rel_a_d;
         rel_b_q    <= rel_b_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
`ifdef PP_READER_FRAMING_EN
         sob_tag_q  <= sob_tag_d;
         eob_tag_q  <= eob_tag_d;
`endif
      end
   end

   // Storage needs no reset: occupancy is tracked by cnt_q alone.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_ent;
   end
endmodule

// File: tb/tb_pp_buffer_reader.sv
// Directed bench for pp_buffer_reader: behavioural RAM banks, stream scoreboard, timing and overrun checks.
module tb_pp_buffer_reader;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;

   pp_buffer_reader_if #(.ADDR_W(8)) bus ();

   pp_buffer_reader #(.BLOCK_BITS(192), .ADDR_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bit ramA [192];
   bit ramB [192];
   always @(posedge clk) begin
      if (bus.rden_A) bus.q_A <= ramA[bus.rdaddress];
      if (bus.rden_B) bus.q_B <= ramB[bus.rdaddress];
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_chk++;
      if (obs != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   bit rx [$];
   bit exp_q [$];
   int issued = 0, popped = 0, addr_err = 0;
   int first_ra, last_ra, n_ra, first_rb, last_rb, n_rb;
   int first_v, last_v, n_v, n_rel_a, n_rel_b, rel_a_cyc, rel_b_cyc;
   bit prev_stall = 0, prev_q = 0;

   task automatic clear_logs();
      rx.delete();
      addr_err = 0;
      first_ra = -1; last_ra = -1; n_ra = 0;
      first_rb = -1; last_rb = -1; n_rb = 0;
      first_v = -1; last_v = -1; n_v = 0;
      n_rel_a = 0; n_rel_b = 0; rel_a_cyc = -1; rel_b_cyc = -1;
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (reset) begin
         issued = 0;
         popped = 0;
         prev_stall = 0;
      end else begin
         chk("rden_exclusive", int'(bus.rden_A & bus.rden_B), 0);
         chk("occupancy_le2", int'((issued - popped) <= 2), 1);
         if (prev_stall) begin
            chk("stall_hold_vld", int'(bus.valid_next), 1);
            chk("stall_hold_q", int'(bus.q), int'(prev_q));
         end
         if (bus.rden_A || bus.rden_B) begin
            if (int'(bus.rdaddress) != issued % 192) addr_err++;
            issued++;
         end
         if (bus.rden_A) begin
            if (first_ra < 0) first_ra = cyc;
            last_ra = cyc; n_ra++;
         end
         if (bus.rden_B) begin
            if (first_rb < 0) first_rb = cyc;
            last_rb = cyc; n_rb++;
         end
         if (bus.valid_next) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc; n_v++;
         end
         if (bus.valid_next && bus.ready_next) begin
`ifdef PP_READER_FRAMING_EN
            chk("sob_next", int'(bus.sob_next), int'(popped % 192 == 0));
            chk("eob_next", int'(bus.eob_next), int'(popped % 192 == 191));
`endif
            rx.push_back(bus.q);
            popped++;
         end
         if (bus.release_A) begin n_rel_a++; rel_a_cyc = cyc; end
         if (bus.release_B) begin n_rel_b++; rel_b_cyc = cyc; end
         prev_stall = bus.valid_next & ~bus.ready_next;
         prev_q = bus.q;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.full_A = 1'b0; bus.full_B = 1'b0; bus.ready_next = 1'b1; reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      clear_logs();
      exp_q.delete();
   endtask

   task automatic pulse_a();
      bus.full_A = 1'b1; tick(); bus.full_A = 1'b0;
   endtask

   task automatic pulse_b();
      bus.full_B = 1'b1; tick(); bus.full_B = 1'b0;
   endtask

   task automatic fill_bank(input bit sel_b);
      for (int i = 0; i < 192; i++) begin
         if (sel_b) begin ramB[i] = 1'($urandom_range(0, 1)); exp_q.push_back(ramB[i]); end
         else       begin ramA[i] = 1'($urandom_range(0, 1)); exp_q.push_back(ramA[i]); end
      end
   endtask

   task automatic append_bank(input bit sel_b);
      for (int i = 0; i < 192; i++) exp_q.push_back(sel_b ? ramB[i] : ramA[i]);
   endtask

   task automatic wait_rx(input int n, input int bound);
      for (int i = 0; i < bound && rx.size() < n; i++) tick();
   endtask

   task automatic cmp_stream(input string tag);
      int errs = 0;
      chk({tag, "_len"}, rx.size(), exp_q.size());
      for (int i = 0; i < rx.size() && i < exp_q.size(); i++)
         if (rx[i] != exp_q[i]) errs++;
      chk({tag, "_bits"}, errs, 0);
   endtask

   int  c0;
   bit  done, found;

   initial begin
      bus.full_A = 1'b0; bus.full_B = 1'b0; bus.ready_next = 1'b1;
      clear_logs();

      // 1: reset values, single bank A drain timing
      do_reset();
      @(negedge clk);
      chk("rst_rden_A", int'(bus.rden_A), 0);
      chk("rst_rden_B", int'(bus.rden_B), 0);
      chk("rst_valid", int'(bus.valid_next), 0);
      chk("rst_q", int'(bus.q), 0);
      chk("rst_release", int'(bus.release_A | bus.release_B), 0);
      chk("rst_overrun", int'(bus.overrun), 0);
      chk("rst_rdaddress", int'(bus.rdaddress), 0);
      tick();
      fill_bank(1'b0);
      c0 = cyc;
      pulse_a();
      wait_rx(192, 400);
      repeat (3) tick();
      chk("t1_first_rden", first_ra, c0 + 2);
      chk("t1_last_rden", last_ra, c0 + 193);
      chk("t1_n_rden", n_ra, 192);
      chk("t1_first_valid", first_v, c0 + 3);
      chk("t1_last_valid", last_v, c0 + 194);
      chk("t1_release_cyc", rel_a_cyc, c0 + 194);
      chk("t1_n_release", n_rel_a, 1);
      chk("t1_addr_seq", addr_err, 0);
      cmp_stream("t1_stream");
      // Now in WAIT_B: a new A pulse must not start a drain.
      pulse_a();
      repeat (10) tick();
      chk("t1_waitb_no_rden", n_ra, 192);

      // 2: A then B back to back
      do_reset();
      fill_bank(1'b0); fill_bank(1'b1);
      c0 = cyc;
      pulse_a();
      repeat (48) tick();
      pulse_b();
      wait_rx(384, 800);
      repeat (3) tick();
      cmp_stream("t2_stream");
      chk("t2_first_rden_A", first_ra, c0 + 2);
      chk("t2_switch_gap", first_rb - last_ra, 2);
      chk("t2_idle_cycles", (last_v - first_v + 1) - 384, 1);
      chk("t2_n_rel_A", n_rel_a, 1);
      chk("t2_n_rel_B", n_rel_b, 1);
      chk("t2_rel_order", int'(rel_a_cyc < rel_b_cyc), 1);
      chk("t2_addr_seq", addr_err, 0);

      // 3: random backpressure over A,B,A
      do_reset();
      fill_bank(1'b0); fill_bank(1'b1);
      done = 1'b0;
      for (int i = 0; i < 4000 && rx.size() < 576; i++) begin
         bus.full_A = (i == 0);
         bus.full_B = (i == 3);
         if (n_rel_a == 1 && !done) begin
            fill_bank(1'b0);
            bus.full_A = 1'b1;
            done = 1'b1;
         end
         bus.ready_next = 1'($urandom_range(0, 1));
         tick();
      end
      bus.full_A = 1'b0; bus.full_B = 1'b0; bus.ready_next = 1'b1;
      repeat (4) tick();
      cmp_stream("t3_stream");
      chk("t3_n_rel_A", n_rel_a, 2);
      chk("t3_n_rel_B", n_rel_b, 1);
      chk("t3_overrun", int'(bus.overrun), 0);

      // 4: full_A coincident with release_A is not an overrun; a double pulse is, and sticks
      do_reset();
      fill_bank(1'b0); fill_bank(1'b1); append_bank(1'b0);
      done = 1'b0;
      for (int i = 0; i < 1500 && rx.size() < 576; i++) begin
         bus.full_A = (i == 0) || (bus.release_A && !done);
         if (bus.release_A) done = 1'b1;
         bus.full_B = (i == 10);
         tick();
      end
      bus.full_A = 1'b0; bus.full_B = 1'b0;
      repeat (4) tick();
      cmp_stream("t4_stream");
      chk("t4_coincident_no_overrun", int'(bus.overrun), 0);
      pulse_a();
      tick();
      chk("t4_single_no_overrun", int'(bus.overrun), 0);
      pulse_a();
      tick();
      chk("t4_double_overrun", int'(bus.overrun), 1);
      repeat (20) tick();
      chk("t4_overrun_sticky", int'(bus.overrun), 1);

      // 5: B alone never drains ahead of A
      do_reset();
      fill_bank(1'b0); fill_bank(1'b1);
      pulse_b();
      repeat (30) tick();
      chk("t5_no_rden_B", n_rb, 0);
      chk("t5_no_rden_A", n_ra, 0);
      chk("t5_no_valid", n_v, 0);
      pulse_a();
      wait_rx(384, 800);
      repeat (3) tick();
      cmp_stream("t5_stream");

      // 6: reset in the middle of bank B
      do_reset();
      fill_bank(1'b0); fill_bank(1'b1);
      pulse_a();
      repeat (4) tick();
      pulse_b();
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         tick();
         if (bus.rden_B && bus.rdaddress == 8'd100) found = 1'b1;
      end
      chk("t6_reached_b100", int'(found), 1);
      chk("t6_no_rel_B_before", n_rel_b, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_logs();
      exp_q.delete();
      @(negedge clk);
      chk("t6_rden_A", int'(bus.rden_A), 0);
      chk("t6_rden_B", int'(bus.rden_B), 0);
      chk("t6_valid", int'(bus.valid_next), 0);
      chk("t6_q", int'(bus.q), 0);
      chk("t6_release", int'(bus.release_A | bus.release_B), 0);
      chk("t6_rdaddress", int'(bus.rdaddress), 0);
      chk("t6_overrun", int'(bus.overrun), 0);
      repeat (10) tick();
      chk("t6_no_rel_B_after", n_rel_b, 0);
      chk("t6_idle_after_reset", n_rb + n_ra + n_v, 0);
      fill_bank(1'b0);
      pulse_a();
      wait_rx(192, 400);
      repeat (3) tick();
      cmp_stream("t6_stream");
      chk("t6_addr_seq", addr_err, 0);
      chk("t6_n_rel_A", n_rel_a, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
